// File: rtl/csr_access_bridge.sv
// csr_access_bridge: issues single CSR operations from a non-core agent onto
// the shared CSR access bus. The core has priority, and a starvation counter
// stalls the core so the bridge always makes progress. The old CSR value of
// each bridge access is returned over a valid/ready response channel.
module csr_access_bridge #(
  parameter int unsigned StarveLimit = 15,
  parameter int unsigned AddrWidth   = 12,
  parameter int unsigned OpWidth     = 3,
  parameter int unsigned ZimmWidth   = 5,
  parameter int unsigned XLen        = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  // request channel from the non-core agent
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [AddrWidth-1:0] req_addr,
  input  logic [OpWidth-1:0]   req_op,
  input  logic [ZimmWidth-1:0] req_zimm,
  input  logic [XLen-1:0]      req_data,
  // response channel
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [XLen-1:0]      rsp_data,
  // core CSR request
  input  logic                 core_csr_enable,
  input  logic [AddrWidth-1:0] core_csr_addr,
  input  logic [OpWidth-1:0]   core_csr_op,
  input  logic [ZimmWidth-1:0] core_rs1_zimm,
  input  logic [XLen-1:0]      core_rs1_data,
  output logic                 core_stall,
  // CSR access bus to the CSR file
  output logic                 csr_enable,
  output logic [AddrWidth-1:0] csr_addr,
  output logic [OpWidth-1:0]   csr_op,
  output logic [ZimmWidth-1:0] rs1_zimm,
  output logic [XLen-1:0]      rs1_data,
  input  logic [XLen-1:0]      csr_rdata
);

  localparam int unsigned CntW = $clog2(StarveLimit + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(StarveLimit);

  typedef enum logic [1:0] {
    IDLE,
    PEND,
    RESP
  } state_e;

  state_e                 state_q, state_d;
  logic [AddrWidth-1:0]   lat_addr_q, lat_addr_d;
  logic [OpWidth-1:0]     lat_op_q, lat_op_d;
  logic [ZimmWidth-1:0]   lat_zimm_q, lat_zimm_d;
  logic [XLen-1:0]        lat_data_q, lat_data_d;
  logic [XLen-1:0]        rsp_data_q, rsp_data_d;
  logic [CntW-1:0]        starve_cnt_q, starve_cnt_d;
  logic                   core_stall_q, core_stall_d;

  logic                   bridge_grant;
  logic                   bridge_drive;

  // Next-state, request latch, starvation tracking and response capture
  always_comb begin
    state_d      = state_q;
    lat_addr_d   = lat_addr_q;
    lat_op_d     = lat_op_q;
    lat_zimm_d   = lat_zimm_q;
    lat_data_d   = lat_data_q;
    rsp_data_d   = rsp_data_q;
    starve_cnt_d = starve_cnt_q;
    core_stall_d = core_stall_q;
    bridge_grant = core_stall_q | ~core_csr_enable;
    bridge_drive = 1'b0;

    unique case (state_q)
      IDLE: begin
        starve_cnt_d = '0;
        core_stall_d = 1'b0;
        if (req_valid) begin
          lat_addr_d = req_addr;
          lat_op_d   = req_op;
          lat_zimm_d = req_zimm;
          lat_data_d = req_data;
          state_d    = PEND;
        end
      end
      PEND: begin
        if (bridge_grant) begin
          bridge_drive = 1'b1;
          rsp_data_d   = csr_rdata;
          starve_cnt_d = '0;
          core_stall_d = 1'b0;
          state_d      = RESP;
        end else begin
          if (starve_cnt_q != CntMax) begin
            starve_cnt_d = starve_cnt_q + CntW'(1);
          end
          if (starve_cnt_d == CntMax) begin
            core_stall_d = 1'b1;
          end
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= IDLE;
      lat_addr_q   <= '0;
      lat_op_q     <= '0;
      lat_zimm_q   <= '0;
      lat_data_q   <= '0;
      rsp_data_q   <= '0;
      starve_cnt_q <= '0;
      core_stall_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      lat_addr_q   <= lat_addr_d;
      lat_op_q     <= lat_op_d;
      lat_zimm_q   <= lat_zimm_d;
      lat_data_q   <= lat_data_d;
      rsp_data_q   <= rsp_data_d;
      starve_cnt_q <= starve_cnt_d;
      core_stall_q <= core_stall_d;
    end
  end

  // Bus mux: bridge fields only in a granted PEND cycle outside reset,
  // otherwise the core passes straight through
  always_comb begin
    csr_enable = core_csr_enable;
    csr_addr   = core_csr_addr;
    csr_op     = core_csr_op;
    rs1_zimm   = core_rs1_zimm;
    rs1_data   = core_rs1_data;
    if (bridge_drive && reset) begin
      csr_enable = 1'b1;
      csr_addr   = lat_addr_q;
      csr_op     = lat_op_q;
      rs1_zimm   = lat_zimm_q;
      rs1_data   = lat_data_q;
    end
  end

  assign req_ready  = (state_q == IDLE);
  assign rsp_valid  = (state_q == RESP);
  assign rsp_data   = rsp_data_q;
  assign core_stall = core_stall_q;

endmodule

// File: tb/tb_csr_access_bridge.sv
// Directed bench for csr_access_bridge: a default-limit instance backed by a
// small CSR file model, and a StarveLimit=3 instance for the starvation case.
module tb_csr_access_bridge;

  localparam logic [2:0] OP_RW  = 3'b001;
  localparam logic [2:0] OP_RS  = 3'b010;
  localparam logic [2:0] OP_RC  = 3'b011;
  localparam logic [2:0] OP_RSI = 3'b110;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_valid3;
  logic        req_ready, req_ready3;
  logic [11:0] req_addr;
  logic [2:0]  req_op;
  logic [4:0]  req_zimm;
  logic [31:0] req_data;
  logic        rsp_valid, rsp_valid3;
  logic        rsp_ready, rsp_ready3;
  logic [31:0] rsp_data, rsp_data3;
  logic        core_csr_enable, core_csr_enable3;
  logic [11:0] core_csr_addr;
  logic [2:0]  core_csr_op;
  logic [4:0]  core_rs1_zimm;
  logic [31:0] core_rs1_data;
  logic        core_stall, core_stall3;
  logic        csr_enable, csr_enable3;
  logic [11:0] csr_addr, csr_addr3;
  logic [2:0]  csr_op, csr_op3;
  logic [4:0]  rs1_zimm, rs1_zimm3;
  logic [31:0] rs1_data, rs1_data3;
  logic [31:0] csr_rdata, csr_rdata3;

  int vectors     = 0;
  int miscompares = 0;

  // CSR file model: 0x300 read-only, 0x305 and 0x340 read/write
  logic [31:0] csr_300 = 32'h0000_1800;
  logic [31:0] csr_305 = 32'h0000_0000;
  logic [31:0] csr_340 = 32'h0000_1234;

  always #5 clk = ~clk;

  csr_access_bridge u_dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_op(req_op), .req_zimm(req_zimm), .req_data(req_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .core_csr_enable(core_csr_enable), .core_csr_addr(core_csr_addr),
    .core_csr_op(core_csr_op), .core_rs1_zimm(core_rs1_zimm), .core_rs1_data(core_rs1_data),
    .core_stall(core_stall),
    .csr_enable(csr_enable), .csr_addr(csr_addr), .csr_op(csr_op),
    .rs1_zimm(rs1_zimm), .rs1_data(rs1_data), .csr_rdata(csr_rdata)
  );

  csr_access_bridge #(.StarveLimit(3)) u_dut3 (
    .clk(clk), .reset(reset),
    .req_valid(req_valid3), .req_ready(req_ready3),
    .req_addr(req_addr), .req_op(req_op), .req_zimm(req_zimm), .req_data(req_data),
    .rsp_valid(rsp_valid3), .rsp_ready(rsp_ready3), .rsp_data(rsp_data3),
    .core_csr_enable(core_csr_enable3), .core_csr_addr(core_csr_addr),
    .core_csr_op(core_csr_op), .core_rs1_zimm(core_rs1_zimm), .core_rs1_data(core_rs1_data),
    .core_stall(core_stall3),
    .csr_enable(csr_enable3), .csr_addr(csr_addr3), .csr_op(csr_op3),
    .rs1_zimm(rs1_zimm3), .rs1_data(rs1_data3), .csr_rdata(csr_rdata3)
  );

  function automatic logic [31:0] csr_next(input logic [31:0] old, input logic [2:0] op,
                                           input logic [4:0] zimm, input logic [31:0] data);
    logic [31:0] src;
    src = op[2] ? {27'd0, zimm} : data;
    case (op[1:0])
      2'b01:   return src;
      2'b10:   return (zimm != 5'd0) ? (old | src) : old;
      2'b11:   return (zimm != 5'd0) ? (old & ~src) : old;
      default: return old;
    endcase
  endfunction

  always_comb begin
    csr_rdata = 32'd0;
    if (csr_enable) begin
      case (csr_addr)
        12'h300: csr_rdata = csr_300;
        12'h305: csr_rdata = csr_305;
        12'h340: csr_rdata = csr_340;
        default: csr_rdata = 32'd0;
      endcase
    end
  end

  always @(posedge clk) begin
    if (csr_enable) begin
      case (csr_addr)
        12'h305: csr_305 <= csr_next(csr_305, csr_op, rs1_zimm, rs1_data);
        12'h340: csr_340 <= csr_next(csr_340, csr_op, rs1_zimm, rs1_data);
        default: ;
      endcase
    end
  end

  // Second instance sees an address-tagged constant pattern
  assign csr_rdata3 = csr_enable3 ? {20'hA5A50, csr_addr3} : 32'd0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one request in IDLE; returns just after the accepting edge
  task automatic issue(input logic [11:0] a, input logic [2:0] op,
                       input logic [4:0] z, input logic [31:0] d);
    req_addr  = a;
    req_op    = op;
    req_zimm  = z;
    req_data  = d;
    req_valid = 1'b1;
    @(negedge clk);
    check("req_ready_idle", req_ready, 1'b1);
    tick();
    req_valid = 1'b0;
  endtask

  // Wait (bounded) for the response, check data, complete the handshake
  task automatic wait_rsp(input string tag, input logic [31:0] exp);
    int n;
    n = 0;
    @(negedge clk);
    while (!rsp_valid && n < 20) begin
      tick();
      @(negedge clk);
      n++;
    end
    check({tag, "_valid"}, rsp_valid, 1'b1);
    check({tag, "_data"}, rsp_data, exp);
    tick();
    @(negedge clk);
    check({tag, "_ready_back"}, req_ready, 1'b1);
    check({tag, "_valid_drop"}, rsp_valid, 1'b0);
    tick();
  endtask

  // Request with an idle core: bus access the cycle after acceptance
  task automatic run_simple(input string tag, input logic [11:0] a, input logic [2:0] op,
                            input logic [4:0] z, input logic [31:0] d, input logic [31:0] exp);
    issue(a, op, z, d);
    @(negedge clk);
    check({tag, "_bus_en"}, csr_enable, 1'b1);
    check({tag, "_bus_addr"}, csr_addr, a);
    check({tag, "_bus_op"}, csr_op, op);
    check({tag, "_bus_zimm"}, rs1_zimm, z);
    check({tag, "_bus_data"}, rs1_data, d);
    check({tag, "_no_rsp_yet"}, rsp_valid, 1'b0);
    tick();
    wait_rsp(tag, exp);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int bridge_seen;
    reset = 1'b0;
    req_valid = 1'b0; req_valid3 = 1'b0;
    rsp_ready = 1'b1; rsp_ready3 = 1'b1;
    req_addr = '0; req_op = '0; req_zimm = '0; req_data = '0;
    core_csr_enable = 1'b1; core_csr_enable3 = 1'b0;
    core_csr_addr = 12'h300; core_csr_op = OP_RS; core_rs1_zimm = 5'd0;
    core_rs1_data = 32'h0;

    // Reset state and core pass-through during reset
    tick();
    tick();
    @(negedge clk);
    check("rst_req_ready", req_ready, 1'b1);
    check("rst_rsp_valid", rsp_valid, 1'b0);
    check("rst_rsp_data", rsp_data, 32'h0);
    check("rst_core_stall", core_stall, 1'b0);
    check("rst_bus_en", csr_enable, 1'b1);
    check("rst_bus_addr", csr_addr, 12'h300);
    tick();
    reset = 1'b1;
    core_csr_enable = 1'b0;
    tick();

    // Idle core: CSRRW then CSRRS x0 readback
    run_simple("rw305", 12'h305, OP_RW, 5'd1, 32'h8000_0010, 32'h0);
    check("rw305_csr", csr_305, 32'h8000_0010);
    run_simple("rd305", 12'h305, OP_RS, 5'd0, 32'h0, 32'h8000_0010);

    // Core priority: core holds the bus for 5 PEND cycles
    core_csr_enable = 1'b1;
    issue(12'h340, OP_RS, 5'd0, 32'h0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("prio_core_addr", csr_addr, 12'h300);
      check("prio_core_en", csr_enable, 1'b1);
      check("prio_no_stall", core_stall, 1'b0);
      tick();
    end
    core_csr_enable = 1'b0;
    @(negedge clk);
    check("prio_bridge_addr", csr_addr, 12'h340);
    check("prio_bridge_en", csr_enable, 1'b1);
    check("prio_stall_low", core_stall, 1'b0);
    tick();
    wait_rsp("prio", 32'h1234);

    // Response backpressure
    rsp_ready = 1'b0;
    issue(12'h305, OP_RS, 5'd0, 32'h0);
    @(negedge clk);
    check("bp_bus_en", csr_enable, 1'b1);
    tick();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("bp_valid_hold", rsp_valid, 1'b1);
      check("bp_data_hold", rsp_data, 32'h8000_0010);
      check("bp_ready_low", req_ready, 1'b0);
      tick();
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    check("bp_valid_last", rsp_valid, 1'b1);
    check("bp_ready_last", req_ready, 1'b0);
    tick();
    @(negedge clk);
    check("bp_ready_back", req_ready, 1'b1);
    check("bp_valid_drop", rsp_valid, 1'b0);
    tick();

    // x0 rule: CSRRC with zimm=0 leaves the CSR alone; CSRRSI 5 sets bits
    run_simple("rc_x0", 12'h340, OP_RC, 5'd0, 32'hFFFF_FFFF, 32'h1234);
    check("rc_x0_csr", csr_340, 32'h1234);
    run_simple("rsi5", 12'h340, OP_RSI, 5'd5, 32'h0, 32'h1234);
    check("rsi5_csr", csr_340, 32'h1235);

    // Non-existent address reads as zero
    run_simple("noaddr", 12'h7C0, OP_RS, 5'd0, 32'h0, 32'h0);

    // Starvation on the StarveLimit=3 instance
    core_csr_enable3 = 1'b1;
    req_addr = 12'h305; req_op = OP_RS; req_zimm = 5'd0; req_data = 32'h0;
    req_valid3 = 1'b1;
    @(negedge clk);
    check("st_req_ready", req_ready3, 1'b1);
    tick();
    req_valid3 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("st_lost_stall", core_stall3, 1'b0);
      check("st_lost_addr", csr_addr3, 12'h300);
      check("st_lost_en", csr_enable3, 1'b1);
      tick();
    end
    @(negedge clk);
    check("st_stall_high", core_stall3, 1'b1);
    check("st_grant_en", csr_enable3, 1'b1);
    check("st_grant_addr", csr_addr3, 12'h305);
    tick();
    @(negedge clk);
    check("st_stall_low", core_stall3, 1'b0);
    check("st_core_back", csr_addr3, 12'h300);
    check("st_rsp_valid", rsp_valid3, 1'b1);
    check("st_rsp_data", rsp_data3, 32'hA5A5_0305);
    tick();
    @(negedge clk);
    check("st_ready_back", req_ready3, 1'b1);
    core_csr_enable3 = 1'b0;
    tick();

    // Reset while the core blocks the bridge in PEND
    core_csr_enable = 1'b1;
    issue(12'h305, OP_RW, 5'd1, 32'hDEAD_BEEF);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("rp_core_addr", csr_addr, 12'h300);
      tick();
    end
    reset = 1'b0;
    tick();
    reset = 1'b1;
    core_csr_enable = 1'b0;
    bridge_seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (csr_enable) bridge_seen++;
      check("rp_rsp_valid", rsp_valid, 1'b0);
      tick();
    end
    check("rp_bus_access", bridge_seen, 32'd0);
    check("rp_req_ready", req_ready, 1'b1);
    check("rp_rsp_data", rsp_data, 32'h0);
    check("rp_csr_kept", csr_305, 32'h8000_0010);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
